// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus blocks: request mode
// encoding, responder state encoding and default bus dimensions.
package bus_pkg;

  localparam int DEFAULT_DATA_WIDTH           = 8;
  localparam int DEFAULT_SLAVE_MEM_ADDR_WIDTH = 12;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_MEM_RD = 3'd4,
    ST_RDATA  = 3'd5
  } state_t;

endpackage

// File: rtl/serial_slave_responder_if.sv
// Serial slave bus: request channel from the interconnect (mode, valid,
// serial write bits) and response channel back (serial read bits, valid,
// ready, parity error).
interface serial_slave_responder_if;

  logic mode_in;
  logic mvalid;
  logic mwdata;
  logic mrdata;
  logic srvalid;
  logic sready;
  logic perr;

  modport master (
    output mode_in, mvalid, mwdata,
    input  mrdata, srvalid, sready, perr
  );

  modport slave (
    input  mode_in, mvalid, mwdata,
    output mrdata, srvalid, sready, perr
  );

endinterface

// File: rtl/slave_bram.sv
// Single-port local memory: synchronous write, read data registered
// through a MEM_LATENCY-deep pipeline.
module slave_bram #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem  [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] pipe [MEM_LATENCY];

  // Write port: store wdata at the closing edge of a write cycle.
  // NOTE: memory arrays get no reset; clearing them would prevent RAM
  // inference and contents must survive a bus reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port: sample the addressed word, then delay it to MEM_LATENCY.
  always_ff @(posedge clk) begin
    pipe[0] <= mem[addr];
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign rdata = pipe[MEM_LATENCY-1];

endmodule

// File: rtl/serial_slave_responder.sv
// Slave-side responder of the serial system bus. Receives mode, address
// and (for writes) data LSB first, executes the access on the local
// slave_bram and shifts read data back LSB first.
// Optional feature macro: SLAVE_PARITY_EN adds an even-parity bit after
// write data (mismatch suppresses the write and pulses perr) and after
// read data. Without it perr stays 0.
module serial_slave_responder
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
  parameter int SLAVE_MEM_ADDR_WIDTH = DEFAULT_SLAVE_MEM_ADDR_WIDTH,
  parameter int MEM_LATENCY          = 1
) (
  input logic                     clk,
  input logic                     rst,
  serial_slave_responder_if.slave bus
);

`ifdef SLAVE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int PB      = PAR_EN ? 1 : 0;
  localparam int W_LAST  = DATA_WIDTH - 1 + PB;   // last serial write bit index
  localparam int R_LAST  = DATA_WIDTH - 1 + PB;   // last serial read bit index
  localparam int CNT_A   = (SLAVE_MEM_ADDR_WIDTH > DATA_WIDTH + 1) ?
                           SLAVE_MEM_ADDR_WIDTH : DATA_WIDTH + 1;
  localparam int CNT_TOP = (CNT_A > MEM_LATENCY) ? CNT_A : MEM_LATENCY;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  state_t                          state;
  mode_t                           mode;
  logic [CNT_W-1:0]                cnt;
  logic [SLAVE_MEM_ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0]           data_sr;
  logic [DATA_WIDTH-1:0]           rd_sr;
  logic                            rd_par;
  logic                            mrdata_q;
  logic                            srvalid_q;
  logic                            sready_q;
  logic                            perr_q;
  logic                            mem_we;
  logic [DATA_WIDTH-1:0]           mem_rdata;

  // A parity failure still passes through MEM_WR, but with the write gated.
  assign mem_we = (state == ST_MEM_WR) && !perr_q;

  slave_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (SLAVE_MEM_ADDR_WIDTH),
    .MEM_LATENCY(MEM_LATENCY)
  ) u_bram (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_sr),
    .wdata(data_sr),
    .rdata(mem_rdata)
  );

  // Request/response FSM with bit counter, shift registers and registered outputs.
  // NOTE: all state here uses non-blocking assignment so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode      <= MODE_READ;
      cnt       <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      rd_sr     <= '0;
      rd_par    <= 1'b0;
      mrdata_q  <= 1'b0;
      srvalid_q <= 1'b0;
      sready_q  <= 1'b1;
      perr_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.mvalid) begin
            mode     <= mode_t'(bus.mode_in);
            addr_sr  <= {bus.mwdata, addr_sr[SLAVE_MEM_ADDR_WIDTH-1:1]};
            cnt      <= CNT_W'(1);
            sready_q <= 1'b0;
            state    <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (bus.mvalid) begin
            addr_sr <= {bus.mwdata, addr_sr[SLAVE_MEM_ADDR_WIDTH-1:1]};
            if (cnt == CNT_W'(SLAVE_MEM_ADDR_WIDTH - 1)) begin
              cnt   <= '0;
              state <= (mode == MODE_WRITE) ? ST_WDATA : ST_MEM_RD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_WDATA: begin
          if (bus.mvalid) begin
            if (PAR_EN && (cnt == CNT_W'(DATA_WIDTH))) begin
              // Trailing bit is even parity: it must equal the XOR of the data.
              perr_q <= (^data_sr) != bus.mwdata;
              cnt    <= '0;
              state  <= ST_MEM_WR;
            end else begin
              data_sr <= {bus.mwdata, data_sr[DATA_WIDTH-1:1]};
              if (cnt == CNT_W'(W_LAST)) begin
                cnt   <= '0;
                state <= ST_MEM_WR;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end

        ST_MEM_WR: begin
          perr_q   <= 1'b0;
          sready_q <= 1'b1;
          state    <= ST_IDLE;
        end

        ST_MEM_RD: begin
          if (cnt == CNT_W'(MEM_LATENCY)) begin
            cnt       <= '0;
            rd_sr     <= mem_rdata;
            rd_par    <= ^mem_rdata;
            mrdata_q  <= mem_rdata[0];
            srvalid_q <= 1'b1;
            state     <= ST_RDATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RDATA: begin
          if (cnt == CNT_W'(R_LAST)) begin
            cnt       <= '0;
            mrdata_q  <= 1'b0;
            srvalid_q <= 1'b0;
            sready_q  <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt   <= cnt + 1'b1;
            rd_sr <= {1'b0, rd_sr[DATA_WIDTH-1:1]};
            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
              mrdata_q <= rd_par;
            end else begin
              mrdata_q <= rd_sr[1];
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mrdata  = mrdata_q;
  assign bus.srvalid = srvalid_q;
  assign bus.sready  = sready_q;
  assign bus.perr    = perr_q;

endmodule

// File: tb/tb_serial_slave_responder.sv
// Self-checking bench for serial_slave_responder: table of directed
// writes/reads, hand-written reset and parity sequences, then random
// traffic against an array model of the slave memory.
module tb_serial_slave_responder;
  import bus_pkg::*;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int LAT = 1;
`ifdef SLAVE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int WR_EDGES = AW + DW + PB + 1;  // first valid bit to memory update
  localparam int RD_LAT   = LAT + 1;           // last address bit to first srvalid

  logic clk = 1'b0;
  logic rst;

  serial_slave_responder_if bus ();

  serial_slave_responder #(
    .DATA_WIDTH          (DW),
    .SLAVE_MEM_ADDR_WIDTH(AW),
    .MEM_LATENCY         (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference memory: a plain array plus a set of addresses written so far.
  logic [DW-1:0] ref_mem [2**AW];
  logic [AW-1:0] written_q [$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            stall_pos;
    int            stall_len;
    int            exp_edges;
  } wvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial write; reports edges from first valid bit until sready returns,
  // count of cycles sready was seen high mid-transaction, and perr right
  // after the last bit.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int stall_pos, input int stall_len, input bit par_good,
                          output int edges, output int sready_hi, output logic perr_end);
    logic [AW+DW:0] sh;
    sh        = {(^d) ^ !par_good, d, a};
    edges     = 0;
    sready_hi = 0;
    for (int i = 0; i < AW + DW + PB; i++) begin
      if (i == stall_pos) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.mvalid  = 1'b0;
          bus.mwdata  = 1'($urandom);
          bus.mode_in = 1'($urandom);
          tick();
          edges++;
          if (bus.sready) sready_hi++;
        end
      end
      bus.mvalid  = 1'b1;
      bus.mwdata  = sh[0];
      bus.mode_in = (i == 0) ? MODE_WRITE : 1'($urandom);
      sh          = sh >> 1;
      tick();
      edges++;
      if (bus.sready) sready_hi++;
    end
    perr_end   = bus.perr;
    bus.mvalid = 1'b0;
    for (int k = 0; k < 10 && !bus.sready; k++) begin
      tick();
      edges++;
    end
  endtask

  // Serial read; returns data, latency from last address edge to srvalid,
  // number of srvalid cycles seen, trailing parity bit and end-state flags.
  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat,
                         output int vcycles, output logic par, output logic idle_ok);
    logic [AW-1:0] sh;
    sh = a;
    for (int i = 0; i < AW; i++) begin
      bus.mvalid  = 1'b1;
      bus.mwdata  = sh[0];
      bus.mode_in = (i == 0) ? MODE_READ : 1'($urandom);
      sh          = sh >> 1;
      tick();
    end
    bus.mvalid = 1'b0;
    lat = 0;
    while (!bus.srvalid && lat < 20) begin
      bus.mwdata = 1'($urandom);
      tick();
      lat++;
    end
    d       = '0;
    par     = 1'b0;
    vcycles = 0;
    for (int b = 0; b < DW + PB; b++) begin
      if (bus.srvalid) vcycles++;
      if (b < DW) d = {bus.mrdata, d[DW-1:1]};
      else        par = bus.mrdata;
      // mvalid must be ignored while read data streams out
      bus.mvalid = 1'($urandom);
      bus.mwdata = 1'($urandom);
      tick();
    end
    bus.mvalid = 1'b0;
    idle_ok = !bus.srvalid && bus.sready && !bus.mrdata;
  endtask

  task automatic write_checked(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int stall_pos, input int stall_len);
    int   edges, shi;
    logic pe;
    do_write(a, d, stall_pos, stall_len, 1'b1, edges, shi, pe);
    check({tag, "_wr_edges"}, edges, WR_EDGES + stall_len);
    check({tag, "_sready_low"}, shi, 0);
    check({tag, "_perr"}, pe, 1'b0);
    ref_mem[a] = d;
    written_q.push_back(a);
  endtask

  task automatic read_checked(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    int            lat, vc;
    logic          par, idle_ok;
    do_read(a, d, lat, vc, par, idle_ok);
    check({tag, "_rdata"}, d, exp);
    check({tag, "_rd_lat"}, lat, RD_LAT);
    check({tag, "_srvalid_len"}, vc, DW + PB);
    check({tag, "_idle_after"}, idle_ok, 1'b1);
    if (PB != 0) check({tag, "_rd_parity"}, par, ^exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t         tbl [5];
    int            edges, shi;
    logic          pe;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    tbl[0] = '{addr: 12'h123, data: 8'hA5, stall_pos: 0, stall_len: 0, exp_edges: WR_EDGES};
    tbl[1] = '{addr: 12'h0F0, data: 8'h5A, stall_pos: 5, stall_len: 3, exp_edges: WR_EDGES + 3};
    tbl[2] = '{addr: 12'h000, data: 8'h66, stall_pos: 0, stall_len: 0, exp_edges: WR_EDGES};
    tbl[3] = '{addr: 12'hFFF, data: 8'h3C, stall_pos: 0, stall_len: 0, exp_edges: WR_EDGES};
    tbl[4] = '{addr: 12'h010, data: 8'h77, stall_pos: 14, stall_len: 2, exp_edges: WR_EDGES + 2};

    rst         = 1'b1;
    bus.mvalid  = 1'b0;
    bus.mwdata  = 1'b0;
    bus.mode_in = 1'b0;
    #12;
    check("reset_sready", bus.sready, 1'b1);
    check("reset_srvalid", bus.srvalid, 1'b0);
    check("reset_mrdata", bus.mrdata, 1'b0);
    check("reset_perr", bus.perr, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed writes from the table, then read each back.
    foreach (tbl[i]) begin
      do_write(tbl[i].addr, tbl[i].data, tbl[i].stall_pos, tbl[i].stall_len, 1'b1, edges, shi, pe);
      check($sformatf("tbl%0d_wr_edges", i), edges, tbl[i].exp_edges);
      check($sformatf("tbl%0d_sready_low", i), shi, 0);
      check($sformatf("tbl%0d_perr", i), pe, 1'b0);
      ref_mem[tbl[i].addr] = tbl[i].data;
      written_q.push_back(tbl[i].addr);
    end
    foreach (tbl[i]) begin
      read_checked($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].data);
    end
    // 0x000 must be untouched by the write to 0xFFF (no wrap).
    read_checked("addr_no_wrap", 12'h000, 8'h66);

    // Reset in the middle of write data: no partial write, next write works.
    begin
      logic [AW+DW-1:0] sh;
      sh = {8'h99, 12'h010};
      for (int i = 0; i < AW + 5; i++) begin
        bus.mvalid  = 1'b1;
        bus.mwdata  = sh[0];
        bus.mode_in = (i == 0) ? MODE_WRITE : 1'b0;
        sh          = sh >> 1;
        tick();
      end
      bus.mvalid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_sready", bus.sready, 1'b1);
      check("midrst_srvalid", bus.srvalid, 1'b0);
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
      read_checked("midrst_mem_kept", 12'h010, 8'h77);
      write_checked("midrst_next_wr", 12'h010, 8'h42, 0, 0);
      read_checked("midrst_next_rd", 12'h010, 8'h42);
    end

`ifdef SLAVE_PARITY_EN
    // Bad parity: write suppressed, perr pulses once; good parity: written.
    write_checked("par_pre", 12'h200, 8'h55, 0, 0);
    do_write(12'h200, 8'h01, 0, 0, 1'b0, edges, shi, pe);
    check("par_bad_perr", pe, 1'b1);
    check("par_bad_perr_clear", bus.perr, 1'b0);
    read_checked("par_bad_mem", 12'h200, 8'h55);
    write_checked("par_good", 12'h200, 8'h01, 0, 0);
    read_checked("par_good_mem", 12'h200, 8'h01);
`endif

    // Random traffic against the reference memory.
    for (int n = 0; n < 40; n++) begin
      if (($urandom_range(0, 1) == 0) || (written_q.size() == 0)) begin
        ra = AW'($urandom);
        rd = DW'($urandom);
        write_checked($sformatf("rnd%0d", n), ra, rd,
                      $urandom_range(1, AW + DW + PB - 1), $urandom_range(0, 3));
      end else begin
        ra = written_q[$urandom_range(0, written_q.size() - 1)];
        read_checked($sformatf("rnd%0d", n), ra, ref_mem[ra]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
